// File: rtl/sad_gesture_matcher.sv
// sad_gesture_matcher
//   Accumulates a sum of absolute differences (SAD) for each gesture template
//   (NUM_SENSORS differences per template), and tracks the template with the
//   minimum SAD over NUM_TEMPLATES templates. It reports the winning index and
//   score with a one-cycle MATCH_VALID pulse.
//
// Optional feature (macro SAD_MATCH_THRESHOLD_EN):
//   When the macro is defined, this module adds the MATCH_THRESH input and the
//   NO_MATCH output. NO_MATCH flags a final best score above the threshold.
//
// Ports:
//   CLK          system clock, rising edge
//   RST          asynchronous, active-high reset
//   START        begin a match run (sampled only in IDLE)
//   ABORT        cancel the current run (wins over START and accepts)
//   DIFF_IN      absolute difference from the subtractor stage
//   DIFF_VALID   DIFF_IN valid
//   DIFF_READY   matcher accepts DIFF_IN this cycle
//   BUSY         run in progress
//   MATCH_VALID  one-cycle pulse, BEST_* valid
//   BEST_IDX     index of the minimum-SAD template (held)
//   BEST_SCORE   minimum SAD value (held)
//   MATCH_THRESH (optional) no-match threshold
//   NO_MATCH     (optional) final best score > MATCH_THRESH (held)

module sad_gesture_matcher #(
  parameter int NUM_SENSORS   = 5,
  parameter int NUM_TEMPLATES = 26,
  parameter int DW            = 15,
  parameter int ACC_W         = 18,
  parameter int IDX_W         = 5
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             START,
  input  logic             ABORT,
  input  logic [DW-1:0]    DIFF_IN,
  input  logic             DIFF_VALID,
  output logic             DIFF_READY,
  output logic             BUSY,
  output logic             MATCH_VALID,
  output logic [IDX_W-1:0] BEST_IDX,
  output logic [ACC_W-1:0] BEST_SCORE
`ifdef SAD_MATCH_THRESHOLD_EN
  ,
  input  logic [ACC_W-1:0] MATCH_THRESH,
  output logic             NO_MATCH
`endif
);

  localparam int SC_W  = (NUM_SENSORS > 1) ? $clog2(NUM_SENSORS) : 1;
  localparam int SUM_W = ACC_W + 1;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ACCUM   = 2'd1,
    COMPARE = 2'd2,
    DONE    = 2'd3
  } state_t;

  state_t state, next_state;

  logic [ACC_W-1:0] acc;
  logic [SC_W-1:0]  sensor_cnt;
  logic [IDX_W-1:0] tmpl_cnt;
  logic [ACC_W-1:0] best_score;
  logic [IDX_W-1:0] best_idx;

  logic             accept;
  logic             last_sensor;
  logic             last_tmpl;
  logic             best_upd;
  logic [ACC_W-1:0] new_best_score;
  logic [IDX_W-1:0] new_best_idx;

  // Unsigned add that clamps to all ones instead of wrapping.
  function automatic logic [ACC_W-1:0] sat_add(input logic [ACC_W-1:0] a,
                                               input logic [DW-1:0]    d);
    logic [SUM_W-1:0] s;
    s = {1'b0, a} + SUM_W'(d);
    if (s[ACC_W]) return '1;
    return s[ACC_W-1:0];
  endfunction

  assign accept      = DIFF_VALID && DIFF_READY;
  assign last_sensor = (sensor_cnt == SC_W'(NUM_SENSORS - 1));
  assign last_tmpl   = (tmpl_cnt == IDX_W'(NUM_TEMPLATES - 1));

  // Strict less-than keeps the lower index on ties.
  assign best_upd       = (acc < best_score);
  assign new_best_score = best_upd ? acc : best_score;
  assign new_best_idx   = best_upd ? tmpl_cnt : best_idx;

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) state <= IDLE;
    else     state <= next_state;
  end

  always_comb begin
    next_state  = state;
    DIFF_READY  = 1'b0;
    BUSY        = 1'b1;
    MATCH_VALID = 1'b0;
    case (state)
      IDLE: begin
        BUSY = 1'b0;
        if (START) next_state = ACCUM;
      end
      ACCUM: begin
        // ABORT wins over any accept in the same cycle.
        DIFF_READY = !ABORT;
        if (ABORT)                            next_state = IDLE;
        else if (DIFF_VALID && last_sensor)   next_state = COMPARE;
      end
      COMPARE: begin
        if (ABORT)          next_state = IDLE;
        else if (last_tmpl) next_state = DONE;
        else                next_state = ACCUM;
      end
      DONE: begin
        MATCH_VALID = !ABORT;
        next_state  = IDLE;
      end
      default: next_state = IDLE;
    endcase
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      acc        <= '0;
      sensor_cnt <= '0;
      tmpl_cnt   <= '0;
      best_score <= '0;
      best_idx   <= '0;
      BEST_IDX   <= '0;
      BEST_SCORE <= '0;
`ifdef SAD_MATCH_THRESHOLD_EN
      NO_MATCH   <= 1'b0;
`endif
    end else begin
      case (state)
        IDLE: begin
          if (START) begin
            acc        <= '0;
            sensor_cnt <= '0;
            tmpl_cnt   <= '0;
            best_score <= '1;
            best_idx   <= '0;
          end
        end
        ACCUM: begin
          if (accept) begin
            acc        <= sat_add(acc, DIFF_IN);
            sensor_cnt <= sensor_cnt + 1'b1;
          end
        end
        COMPARE: begin
          if (!ABORT) begin
            best_score <= new_best_score;
            best_idx   <= new_best_idx;
            acc        <= '0;
            sensor_cnt <= '0;
            if (last_tmpl) begin
              // Publish the post-compare winner on the edge into DONE.
              BEST_IDX   <= new_best_idx;
              BEST_SCORE <= new_best_score;
`ifdef SAD_MATCH_THRESHOLD_EN
              NO_MATCH   <= (new_best_score > MATCH_THRESH);
`endif
            end else begin
              tmpl_cnt <= tmpl_cnt + 1'b1;
            end
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_sad_gesture_matcher.sv
module tb_sad_gesture_matcher;

  logic        CLK;
  logic        RST;
  logic        START;
  logic        ABORT;
  logic [14:0] DIFF_IN;
  logic        DIFF_VALID;

  logic        DIFF_READY, BUSY, MATCH_VALID;
  logic [4:0]  BEST_IDX;
  logic [17:0] BEST_SCORE;

  logic        ready_b, busy_b, mv_b;
  logic [4:0]  idx_b;
  logic [15:0] score_b;

`ifdef SAD_MATCH_THRESHOLD_EN
  logic [17:0] match_thresh;
  logic        no_match;
  logic [15:0] thresh_b;
  logic        no_match_b;
`endif

  sad_gesture_matcher #(.NUM_TEMPLATES(4)) dut_a (
    .CLK(CLK), .RST(RST), .START(START), .ABORT(ABORT),
    .DIFF_IN(DIFF_IN), .DIFF_VALID(DIFF_VALID), .DIFF_READY(DIFF_READY),
    .BUSY(BUSY), .MATCH_VALID(MATCH_VALID),
    .BEST_IDX(BEST_IDX), .BEST_SCORE(BEST_SCORE)
`ifdef SAD_MATCH_THRESHOLD_EN
    , .MATCH_THRESH(match_thresh), .NO_MATCH(no_match)
`endif
  );

  sad_gesture_matcher #(.NUM_TEMPLATES(4), .ACC_W(16)) dut_b (
    .CLK(CLK), .RST(RST), .START(START), .ABORT(ABORT),
    .DIFF_IN(DIFF_IN), .DIFF_VALID(DIFF_VALID), .DIFF_READY(ready_b),
    .BUSY(busy_b), .MATCH_VALID(mv_b),
    .BEST_IDX(idx_b), .BEST_SCORE(score_b)
`ifdef SAD_MATCH_THRESHOLD_EN
    , .MATCH_THRESH(thresh_b), .NO_MATCH(no_match_b)
`endif
  );

  int total_cnt = 0;
  int pass_cnt  = 0;
  int mv_cnt    = 0;

  int set1[20] = '{20, 20, 20, 20, 20,
                   10,  5, 15,  0, 10,
                    8,  8,  8,  8,  8,
                   30,  0, 30,  0, 30};
  int cur[20];

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  always @(posedge CLK) if (MATCH_VALID) mv_cnt++;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total_cnt++;
    if (obs === exp) pass_cnt++;
    else $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
  endtask

  task automatic start_run();
    START = 1'b1;
    @(negedge CLK);
    START = 1'b0;
  endtask

  task automatic send(input int d);
    int n;
    DIFF_VALID = 1'b1;
    DIFF_IN    = 15'(d);
    n = 0;
    while (!DIFF_READY && n < 50) begin
      @(negedge CLK);
      n++;
    end
    if (n >= 50) check_eq("ready_timeout", 0, 1);
    @(negedge CLK);
    DIFF_VALID = 1'b0;
  endtask

  // Full run: START, all 20 differences, then checks at COMPARE/DONE/IDLE.
  task automatic run_full(input int gap, input int start_at,
                          input int ea_idx, input int ea_score,
                          input int eb_idx, input int eb_score);
    int mv0;
    mv0 = mv_cnt;
    start_run();
    for (int i = 0; i < 20; i++) begin
      if (i == start_at) START = 1'b1;
      send(cur[i]);
      START = 1'b0;
      if (i % 5 == 4) check_eq("ready_in_compare", DIFF_READY, 0);
      if (gap != 0 && i != 19) @(negedge CLK);
    end
    check_eq("mv_in_compare", MATCH_VALID, 0);
    @(negedge CLK);
    check_eq("mv_pulse", MATCH_VALID, 1);
    check_eq("busy_done", BUSY, 1);
    check_eq("best_idx", BEST_IDX, ea_idx);
    check_eq("best_score", BEST_SCORE, ea_score);
    check_eq("b_mv", mv_b, 1);
    check_eq("b_idx", idx_b, eb_idx);
    check_eq("b_score", score_b, eb_score);
`ifdef SAD_MATCH_THRESHOLD_EN
    check_eq("no_match", no_match, (ea_score > int'(match_thresh)) ? 1 : 0);
    check_eq("b_no_match", no_match_b, 0);
`endif
    @(negedge CLK);
    check_eq("mv_after", MATCH_VALID, 0);
    check_eq("busy_idle", BUSY, 0);
    check_eq("mv_count", mv_cnt - mv0, 1);
  endtask

  initial begin
    int mv0;
    RST = 1'b1; START = 1'b0; ABORT = 1'b0; DIFF_IN = '0; DIFF_VALID = 1'b0;
`ifdef SAD_MATCH_THRESHOLD_EN
    match_thresh = 18'd1000;
    thresh_b     = 16'hFFFF;
`endif
    repeat (2) @(negedge CLK);
    check_eq("rst_busy", BUSY, 0);
    check_eq("rst_ready", DIFF_READY, 0);
    check_eq("rst_mv", MATCH_VALID, 0);
    check_eq("rst_idx", BEST_IDX, 0);
    check_eq("rst_score", BEST_SCORE, 0);
    check_eq("rst_b_busy", busy_b, 0);
    check_eq("rst_b_ready", ready_b, 0);
    RST = 1'b0;
    @(negedge CLK);

    // Sums 100, 40, 40, 90: tie keeps index 1.
    for (int i = 0; i < 20; i++) cur[i] = set1[i];
    run_full(0, -1, 1, 40, 1, 40);

    // Same data, DIFF_VALID every other cycle.
    run_full(1, -1, 1, 40, 1, 40);

    // All 0x7FFF: 18-bit sums 163835 exactly, 16-bit saturates at 0xFFFF.
    for (int i = 0; i < 20; i++) cur[i] = 32'h7FFF;
    run_full(0, -1, 0, 163835, 0, 16'hFFFF);

    // Run 1 re-establishes 1/40, then run 2 is aborted in template 2.
    for (int i = 0; i < 20; i++) cur[i] = set1[i];
    run_full(0, -1, 1, 40, 1, 40);
    mv0 = mv_cnt;
    start_run();
    for (int i = 0; i < 12; i++) send(set1[i]);
    DIFF_VALID = 1'b1; DIFF_IN = 15'd8; ABORT = 1'b1; START = 1'b1;
    @(negedge CLK);
    ABORT = 1'b0; START = 1'b0; DIFF_VALID = 1'b0;
    check_eq("abort_busy", BUSY, 0);
    check_eq("abort_mv", MATCH_VALID, 0);
    check_eq("abort_idx", BEST_IDX, 1);
    check_eq("abort_score", BEST_SCORE, 40);
    @(negedge CLK);
    check_eq("abort_idle", BUSY, 0);
    check_eq("abort_no_pulse", mv_cnt - mv0, 0);

    // Fresh run after ABORT with different data: sums 90,100,40,100 -> idx 2.
    cur = '{30, 0, 30, 0, 30,  20, 20, 20, 20, 20,
            10, 5, 15, 0, 10,  20, 20, 20, 20, 20};
    run_full(0, -1, 2, 40, 2, 40);

    // START pulsed mid-run is ignored.
    for (int i = 0; i < 20; i++) cur[i] = set1[i];
    run_full(0, 7, 1, 40, 1, 40);

`ifdef SAD_MATCH_THRESHOLD_EN
    match_thresh = 18'd39;
    run_full(0, -1, 1, 40, 1, 40);
    match_thresh = 18'd40;
    run_full(0, -1, 1, 40, 1, 40);
`endif

    // RST asserted while in COMPARE clears outputs asynchronously.
    start_run();
    for (int i = 0; i < 5; i++) send(set1[i]);
    check_eq("pre_rst_busy", BUSY, 1);
    #1 RST = 1'b1;
    #1;
    check_eq("arst_busy", BUSY, 0);
    check_eq("arst_ready", DIFF_READY, 0);
    check_eq("arst_mv", MATCH_VALID, 0);
    check_eq("arst_idx", BEST_IDX, 0);
    check_eq("arst_score", BEST_SCORE, 0);
    check_eq("arst_b_score", score_b, 0);
`ifdef SAD_MATCH_THRESHOLD_EN
    check_eq("arst_no_match", no_match, 0);
`endif
    @(negedge CLK);
    RST = 1'b0;
    @(negedge CLK);
    check_eq("post_rst_idle", BUSY, 0);

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: got 0 expected 1");
    $fatal(1);
  end

endmodule
